// File: rtl/sum_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sum_xfer_ctrl
// Brief    : Partial-sum exchange controller: sends n_item local items, then receives n_item peer items.
// Revision : 1.0
// ============================================================================
module sum_xfer_ctrl #(
    parameter int bw     = 8,
    parameter int n_item = 8,
    parameter int tmo    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          local_valid,
    input  logic [bw-1:0] local_sum,
    output logic          local_ready,
    input  logic          fifo_full,
    output logic          fifo_wr,
    output logic [bw-1:0] fifo_wdata,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [bw-1:0] fifo_rdata,
    output logic [bw-1:0] peer_sum,
    output logic          peer_valid,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);

    localparam int c_CNT_W = $clog2(n_item + 1);
    localparam int c_TMO_W = $clog2(tmo + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_ITEM = c_CNT_W'(n_item - 1);
    localparam logic [c_TMO_W-1:0] c_LAST_STALL = c_TMO_W'(tmo - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_RECV  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   send_cnt_q, send_cnt_d;
    logic [c_CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [c_TMO_W-1:0]   stall_q, stall_d;
    logic [bw-1:0]        peer_sum_q;
    logic                 peer_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            send_cnt_q   <= '0;
            recv_cnt_q   <= '0;
            stall_q      <= '0;
            peer_sum_q   <= '0;
            peer_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            send_cnt_q   <= send_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            stall_q      <= stall_d;
            peer_valid_q <= fifo_rd;
            if (fifo_rd) begin
                peer_sum_q <= fifo_rdata;
            end
        end
    end

    // Stall counter defaults to clear; it only counts in SEND/RECV on
    // cycles without a transfer and while the state is unchanged.
    always_comb begin
        state_d     = state_q;
        send_cnt_d  = send_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        stall_d     = '0;
        local_ready = 1'b0;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        timeout_err = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                fifo_wr     = local_valid & ~fifo_full;
                local_ready = fifo_wr;
                if (fifo_wr) begin
                    if (send_cnt_q >= c_LAST_ITEM) begin
                        send_cnt_d = '0;
                        state_d    = S_RECV;
                    end else begin
                        send_cnt_d = send_cnt_q + 1'b1;
                    end
                end else if (stall_q == c_LAST_STALL) begin
                    state_d = S_ERR;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_RECV: begin
                fifo_rd = ~fifo_empty;
                if (fifo_rd) begin
                    if (recv_cnt_q >= c_LAST_ITEM) begin
                        recv_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        recv_cnt_d = recv_cnt_q + 1'b1;
                    end
                end else if (stall_q == c_LAST_STALL) begin
                    state_d = S_ERR;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                busy        = 1'b0;
                timeout_err = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign fifo_wdata = local_sum;
    assign peer_sum   = peer_sum_q;
    assign peer_valid = peer_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_xfer_ctrl
// Brief    : Directed self-checking bench for sum_xfer_ctrl.
// Revision : 1.0
// ============================================================================
module tb_sum_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       local_valid;
    logic [7:0] local_sum;
    logic       local_ready;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_rdata;
    logic [7:0] peer_sum;
    logic       peer_valid;
    logic       busy;
    logic       done;
    logic       timeout_err;

    always #5 clk = ~clk;

    sum_xfer_ctrl #(
        .bw    (8),
        .n_item(8),
        .tmo   (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .local_valid(local_valid),
        .local_sum  (local_sum),
        .local_ready(local_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata),
        .peer_sum   (peer_sum),
        .peer_valid (peer_valid),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Local source advances on each accepted item; the incoming FIFO shows
    // its head item and pops it on fifo_rd.
    int tx_cnt  = 0;
    int rx_idx  = 0;
    int rx_base = 0;
    always @(posedge clk) begin
        if (local_ready === 1'b1) tx_cnt <= tx_cnt + 1;
        if (fifo_rd === 1'b1)     rx_idx <= rx_idx + 1;
    end
    assign local_sum  = 8'(32'hA0 + tx_cnt);
    assign fifo_rdata = 8'((((rx_idx - rx_base) & 15) + 1) * 17);

    int cyc = 0, wr_cnt = 0, rd_cnt = 0, pv_cnt = 0, done_cnt = 0, err_cnt = 0;
    int start_cyc = 0, err_cyc = 0;
    int wr_cyc [128];
    int rd_cyc [128];
    int done_cyc [32];
    logic [7:0] pv_data [128];
    int lag_err = 0, ovl_err = 0, rde_err = 0, bp_err = 0, rdy_err = 0, wd_err = 0, seq_err = 0;
    logic prev_rd = 1'b0, prev_terr = 1'b0, have_w = 1'b0;
    logic [7:0] last_w = 8'h00;

    always @(negedge clk) begin
        if (start && !reset) start_cyc = cyc;
        if (fifo_wr) begin
            if (wr_cnt < 128) wr_cyc[wr_cnt] = cyc;
            wr_cnt++;
            if (fifo_wdata !== local_sum) wd_err++;
            if (have_w && fifo_wdata !== 8'(last_w + 8'd1)) seq_err++;
            last_w = fifo_wdata;
            have_w = 1'b1;
        end
        if (fifo_rd) begin
            if (rd_cnt < 128) rd_cyc[rd_cnt] = cyc;
            rd_cnt++;
        end
        if (peer_valid) begin
            if (pv_cnt < 128) pv_data[pv_cnt] = peer_sum;
            pv_cnt++;
        end
        if (peer_valid !== prev_rd) lag_err++;
        prev_rd = fifo_rd;
        if (fifo_wr && fifo_rd) ovl_err++;
        if (fifo_rd && fifo_empty) rde_err++;
        if (fifo_full && (fifo_wr || local_ready)) bp_err++;
        if (local_ready !== fifo_wr) rdy_err++;
        if (done) begin
            if (done_cnt < 32) done_cyc[done_cnt] = cyc;
            done_cnt++;
        end
        if (timeout_err && !prev_terr) begin
            err_cyc = cyc;
            err_cnt++;
        end
        prev_terr = timeout_err;
        cyc++;
    end

    int b_wr, b_rd, b_pv, b_done, b_err;

    task automatic snap();
        b_wr    = wr_cnt;
        b_rd    = rd_cnt;
        b_pv    = pv_cnt;
        b_done  = done_cnt;
        b_err   = err_cnt;
        rx_base = rx_idx;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_done(input string tg, input int maxc, input bit tgl);
        for (int i = 0; i < maxc && done_cnt == b_done; i++) begin
            @(posedge clk); #1;
            if (tgl) fifo_empty = ~fifo_empty;
        end
        chk({tg, "_done_seen"}, int'(done_cnt > b_done), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // exp_lat counts cycles from the start cycle to the done cycle inclusive.
    task automatic check_txn(input string tg, input int exp_lat);
        int perr;
        perr = 0;
        chk({tg, "_writes"}, wr_cnt - b_wr, 8);
        chk({tg, "_reads"}, rd_cnt - b_rd, 8);
        chk({tg, "_peer_valids"}, pv_cnt - b_pv, 8);
        chk({tg, "_done_pulses"}, done_cnt - b_done, 1);
        for (int i = 0; i < 8; i++) begin
            if (b_pv + i < 128 && pv_data[b_pv + i] !== 8'((i + 1) * 17)) perr++;
        end
        chk({tg, "_peer_order_errs"}, perr, 0);
        chk({tg, "_busy_after"}, int'(busy), 0);
        if (exp_lat > 0) begin
            chk({tg, "_done_latency"},
                (done_cnt > b_done) ? done_cyc[b_done] - start_cyc + 1 : -1, exp_lat);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        local_valid = 1'b1;
        fifo_full   = 1'b0;
        fifo_empty  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", int'({local_ready, fifo_wr, fifo_rd, peer_valid, busy, done, timeout_err}), 0);
        chk("rst_peer_sum", int'(peer_sum), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal transaction
        snap();
        do_start();
        run_done("nom", 60, 1'b0);
        check_txn("nom", 19);
        chk("nom_first_wr", wr_cyc[b_wr] - start_cyc, 1);
        chk("nom_first_rd", rd_cyc[b_rd] - start_cyc, 9);
        chk("nom_rd_span", rd_cyc[b_rd + 7] - rd_cyc[b_rd], 7);

        // Backpressure: five full cycles inside SEND
        snap();
        do_start();
        @(posedge clk); #1;
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 fifo_full = 1'b0;
        run_done("bp", 60, 1'b0);
        check_txn("bp", 24);

        // Incoming FIFO empty on alternate cycles
        fifo_empty = 1'b1;
        snap();
        do_start();
        run_done("gap", 80, 1'b1);
        check_txn("gap", 0);
        fifo_empty = 1'b0;

        // Second start while in RECV
        snap();
        do_start();
        repeat (11) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_done("busy", 60, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check_txn("busy", 0);

        // Receive stall timeout
        fifo_empty = 1'b1;
        snap();
        do_start();
        repeat (280) @(posedge clk);
        #1;
        chk("tmo_err_pulses", err_cnt - b_err, 1);
        chk("tmo_err_latency", err_cyc - start_cyc, 264);
        chk("tmo_flag", int'(timeout_err), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_writes", wr_cnt - b_wr, 8);
        fifo_empty = 1'b0;
        do_start();
        repeat (10) @(posedge clk);
        #1;
        chk("tmo_start_ignored_busy", int'(busy), 0);
        chk("tmo_start_ignored_wr", wr_cnt - b_wr, 8);
        chk("tmo_no_reads", rd_cnt - b_rd, 0);
        chk("tmo_flag_sticky", int'(timeout_err), 1);
        chk("tmo_no_done", done_cnt - b_done, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("tmo_cleared_by_reset", int'(timeout_err), 0);

        // Reset after three writes, with a coincident start
        snap();
        do_start();
        for (int i = 0; i < 20 && (wr_cnt - b_wr) < 3; i++) begin
            @(negedge clk); #1;
        end
        chk("rmid_wr_before", wr_cnt - b_wr, 3);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("rmid_outputs", int'({local_ready, fifo_wr, fifo_rd, peer_valid, busy, done, timeout_err}), 0);
        chk("rmid_peer_sum", int'(peer_sum), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rmid_start_ignored", int'(busy), 0);
        chk("rmid_no_more_writes", wr_cnt - b_wr, 3);
        snap();
        do_start();
        run_done("fresh", 60, 1'b0);
        check_txn("fresh", 19);

        chk("mon_peer_lag", lag_err, 0);
        chk("mon_wr_rd_overlap", ovl_err, 0);
        chk("mon_rd_when_empty", rde_err, 0);
        chk("mon_wr_when_full", bp_err, 0);
        chk("mon_ready_ne_wr", rdy_err, 0);
        chk("mon_wdata_ne_local", wd_err, 0);
        chk("mon_send_sequence", seq_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
